pc_fetch_ctrl: RTL
==================

# pc_fetch_ctrl

Program-counter and instruction-fetch controller for the single-cycle RV64 core. It sits directly downstream of the branch selector and consumes its `sel` decision together with the immediate to form the next PC. It holds the PC register, runs a request/acknowledge handshake with instruction memory, and presents one instruction at a time to decode/execute. It traps on misaligned branch targets or instruction-memory timeout.

## Interface
- `RESET_PC`, default 64'h0: PC loaded on reset.
- `ACK_TIMEOUT`, default 16: maximum cycles in REQ without `imem_ack` before a timeout trap; must be ≥1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  branch-taken decision from the selector; sampled only with `retire`.
- `imm`  in  64  sign-extended immediate from imm-gen, in halfword units; sampled only with `retire`.
- `retire`  in  1  execute has consumed the current instruction.
- `imem_ack`  in  1  instruction memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  64  fetch address, equal to `pc`.
- `pc`  out  64  current PC.
- `instr`  out  32  instruction presented to decode.
- `instr_valid`  out  1  `instr` is valid and awaiting `retire`.
- `trap`  out  1  sticky trap flag.
- `trap_cause`  out  2  2'b00 none, 2'b01 misaligned target, 2'b10 fetch timeout.

## Operation
- States: IDLE, REQ, HOLD, TRAP.
- IDLE: entered on reset and left unconditionally next cycle for REQ.
- REQ: `imem_req`=1 and `imem_addr`=`pc`. The timeout counter increments each cycle. When `imem_ack`=1, capture `imem_rdata` into `instr`, set `instr_valid`, clear the counter and go to HOLD. When the counter reaches `ACK_TIMEOUT`-1 without ack, go to TRAP with cause 2'b10. Ack in the same cycle as expiry wins.
- HOLD: `instr_valid`=1 and `imem_req`=0. On `retire`:
  - next = `sel` ? `pc` + (`imm` << 1) : `pc` + 4.
  - If next[1:0] ≠ 0, go to TRAP with cause 2'b01 and leave `pc` unchanged.
  - Otherwise load `pc` ← next, clear `instr_valid` and go to REQ.
- TRAP: `trap`=1, `imem_req`=0, `instr_valid`=0, `pc` frozen. Only reset leaves TRAP.
- Arithmetic: 64-bit modulo 2^64. `imm` << 1 discards bit 63. PC wrap from 64'hFFFF_FFFF_FFFF_FFFC + 4 gives 0 with no trap.
- Ignored inputs:
  - `retire` outside HOLD.
  - `imem_ack` outside REQ.
  - `sel` and `imm` when `retire`=0.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, `imem_addr`=`RESET_PC`.
  - `imem_req`=0, `instr`=32'h0, `instr_valid`=0, `trap`=0, `trap_cause`=2'b00.
  - State IDLE, counter 0.
- The first `imem_req` rises 1 cycle after `reset` deasserts.
- All outputs are registered except `imem_addr`, which is a combinational copy of `pc`.
- `instr_valid` rises the cycle after the ack edge. The new `pc` and `imem_req` appear the cycle after the retire edge.
- Minimum throughput is 2 cycles per instruction, with ack and retire each arriving immediately.
- Reset mid-REQ or mid-HOLD abandons the transaction at that edge. A late ack after reset is ignored because the state is IDLE.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`=64.
  - `fetch_state_t` enum {IDLE, REQ, HOLD, TRAP}.
  - Trap-cause constants `TRAP_NONE`, `TRAP_MISALIGN`, `TRAP_TIMEOUT`.
- One combinational sub-module `pc_next_calc` takes `pc`, `imm` and `sel` and produces the next PC and a misaligned flag. The FSM, counter and registers stay in `pc_fetch_ctrl`.

## Test plan
- Reset → first fetch: `RESET_PC`=64'h1000, release reset, ack 2 cycles later with 32'h00000013 → `imem_addr`=64'h1000, `instr_valid` rises, `instr`=32'h00000013.
- Sequential flow: retire with `sel`=0 at `pc`=64'h1000 → next `imem_addr`=64'h1004; repeat 3× → 64'h100C.
- Taken branch: `pc`=64'h1010, `sel`=1, `imm`=-8 (64'hFFFF_FFFF_FFFF_FFF8) → `pc`=64'h1000. With `imm`=1 → target 64'h1012, `trap`=1, `trap_cause`=2'b01, `pc` stays 64'h1010.
- Timeout: `ACK_TIMEOUT`=4, never ack → `trap_cause`=2'b10 after 4 REQ cycles, `imem_req`=0. Ack exactly on the 4th cycle → no trap, HOLD.
- Wrap and ignored inputs: `pc`=64'hFFFF_FFFF_FFFF_FFFC, retire with `sel`=0 → `pc`=0, no trap. `retire` pulsed during REQ and ack pulsed during HOLD → no state or `pc` change.
- Reset mid-operation: assert `reset` in HOLD at `pc`=64'h2000 → next cycle `pc`=`RESET_PC`, `instr_valid`=0, and a stray ack in IDLE is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions: data width, fetch FSM states and trap cause codes.
package riscv_pkg;

  localparam int XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    TRAP
  } fetch_state_t;

  localparam logic [1:0] TRAP_NONE     = 2'b00;
  localparam logic [1:0] TRAP_MISALIGN = 2'b01;
  localparam logic [1:0] TRAP_TIMEOUT  = 2'b10;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC adder: taken branch adds the halfword immediate, else pc + 4.
module pc_next_calc
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            sel,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] offset;

  // imm counts halfwords; the shift drops bit 63, giving modulo-2^64 arithmetic
  assign offset     = sel ? (imm << 1) : XLEN'(4);
  assign next_pc    = pc + offset;
  assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and instruction-fetch handshake controller with misalign/timeout traps.
module pc_fetch_ctrl
  import riscv_pkg::*;
#(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int          ACK_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sel,
  input  logic [XLEN-1:0] imm,
  input  logic            retire,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr,
  output logic            instr_valid,
  output logic            trap,
  output logic [1:0]      trap_cause
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  fetch_state_t    state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [31:0]     instr_reg, instr_next;
  logic            valid_reg, valid_next;
  logic            req_reg, req_next;
  logic            trap_reg, trap_next;
  logic [1:0]      cause_reg, cause_next;

  logic [XLEN-1:0] target_pc;
  logic            target_misaligned;

  pc_next_calc u_pc_next_calc (
    .pc         (pc_reg),
    .imm        (imm),
    .sel        (sel),
    .next_pc    (target_pc),
    .misaligned (target_misaligned)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    valid_next = valid_reg;
    cause_next = cause_reg;
    case (state_reg)
      IDLE: begin
        state_next = REQ;
        cnt_next   = '0;
      end
      REQ: begin
        // an ack arriving on the expiry cycle still completes the fetch
        if (imem_ack) begin
          instr_next = imem_rdata;
          valid_next = 1'b1;
          cnt_next   = '0;
          state_next = HOLD;
        end else if (cnt_reg == CNT_LAST) begin
          cause_next = TRAP_TIMEOUT;
          state_next = TRAP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (retire) begin
          valid_next = 1'b0;
          if (target_misaligned) begin
            cause_next = TRAP_MISALIGN;
            state_next = TRAP;
          end else begin
            pc_next    = target_pc;
            cnt_next   = '0;
            state_next = REQ;
          end
        end
      end
      TRAP: begin
        state_next = TRAP;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    req_next  = (state_next == REQ);
    trap_next = (state_next == TRAP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      pc_reg    <= RESET_PC;
      instr_reg <= 32'h0;
      valid_reg <= 1'b0;
      req_reg   <= 1'b0;
      trap_reg  <= 1'b0;
      cause_reg <= TRAP_NONE;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      valid_reg <= valid_next;
      req_reg   <= req_next;
      trap_reg  <= trap_next;
      cause_reg <= cause_next;
    end
  end

  assign imem_req    = req_reg;
  assign imem_addr   = pc_reg;
  assign pc          = pc_reg;
  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign trap        = trap_reg;
  assign trap_cause  = cause_reg;

endmodule
